// File: rtl/pcpi_mul_arbiter.sv
// pcpi_mul_arbiter
//   Shares one PCPI multiplier between two PCPI requesters (ports 0 and 1).
//   A port requests when it presents a valid RV32M MUL-group instruction
//   (opcode 0110011, funct7 0000001, funct3[2]=0). Requests are granted
//   round-robin, operands are registered toward the multiplier, and the
//   result is returned to the granted port as a one-cycle ready/wr strobe.
//   A BUSY transaction ends on m_ready, on a TIMEOUT abort (err pulse) or
//   when the granted requester drops valid. Every transaction is followed
//   by two COOL cycles with m_valid low.
//
// Ports
//   clk, resetn                    clock, synchronous active-low reset
//   pN_valid/insn/rs1/rs2 (N=0,1)  requester N PCPI request
//   pN_wr/rd/wait/ready            requester N PCPI response
//   m_valid/insn/rs1/rs2           registered request to the multiplier
//   m_wr/rd/ready                  multiplier response
//   err                            one-cycle pulse on timeout abort
module pcpi_mul_arbiter #(
    parameter int TIMEOUT = 80
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_valid,
    input  logic [31:0] p0_insn,
    input  logic [31:0] p0_rs1,
    input  logic [31:0] p0_rs2,
    output logic        p0_wr,
    output logic [31:0] p0_rd,
    output logic        p0_wait,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [31:0] p1_insn,
    input  logic [31:0] p1_rs1,
    input  logic [31:0] p1_rs2,
    output logic        p1_wr,
    output logic [31:0] p1_rd,
    output logic        p1_wait,
    output logic        p1_ready,
    output logic        m_valid,
    output logic [31:0] m_insn,
    output logic [31:0] m_rs1,
    output logic [31:0] m_rs2,
    input  logic        m_wr,
    input  logic        m_ready,
    input  logic [31:0] m_rd,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;

    state_t          state;
    logic   [CW-1:0] cnt;
    logic            cool;
    logic            gnt;        // port owning the current transaction
    logic            last_gnt;   // port granted most recently
    logic   [1:0]    cand;       // port presents a MUL-group instruction
    logic   [1:0]    done;       // port finished, holding valid until it drops
    logic   [1:0]    pend;       // port still owed a response
    logic   [1:0]    rdy_q;
    logic   [1:0]    wr_q;
    logic   [31:0]   rd_q [2];
    logic            pick;
    logic            g_valid;

    function automatic logic is_mul(input logic [31:0] insn);
        return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && !insn[14];
    endfunction

    assign cand[0] = p0_valid && is_mul(p0_insn);
    assign cand[1] = p1_valid && is_mul(p1_insn);
    assign pend    = cand & ~done;

    // On a tie the port not granted last time wins; otherwise the lone requester.
    assign pick    = (&pend) ? ~last_gnt : pend[1];
    assign g_valid = gnt ? p1_valid : p0_valid;

    // wait is gated by resetn so it reads 0 for the whole reset window.
    assign p0_wait  = resetn && pend[0];
    assign p1_wait  = resetn && pend[1];
    assign p0_ready = rdy_q[0];
    assign p1_ready = rdy_q[1];
    assign p0_wr    = wr_q[0];
    assign p1_wr    = wr_q[1];
    assign p0_rd    = rd_q[0];
    assign p1_rd    = rd_q[1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            cool     <= 1'b0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;   // makes port 0 win the first tie
            done     <= 2'b00;
            rdy_q    <= 2'b00;
            wr_q     <= 2'b00;
            rd_q[0]  <= '0;
            rd_q[1]  <= '0;
            m_valid  <= 1'b0;
            m_insn   <= '0;
            m_rs1    <= '0;
            m_rs2    <= '0;
            err      <= 1'b0;
        end else begin
            rdy_q <= 2'b00;
            wr_q  <= 2'b00;
            err   <= 1'b0;
            // A finished port is not re-served until it has dropped valid.
            if (!p0_valid) done[0] <= 1'b0;
            if (!p1_valid) done[1] <= 1'b0;

            case (state)
                IDLE: begin
                    if (|pend) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        m_insn   <= pick ? p1_insn : p0_insn;
                        m_rs1    <= pick ? p1_rs1  : p0_rs1;
                        m_rs2    <= pick ? p1_rs2  : p0_rs2;
                        m_valid  <= 1'b1;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Requester drop outranks m_ready: the result is discarded.
                    if (!g_valid) begin
                        m_valid <= 1'b0;
                        cool    <= 1'b0;
                        state   <= COOL;
                    end else if (m_ready) begin
                        rdy_q[gnt] <= 1'b1;
                        wr_q[gnt]  <= m_wr;
                        rd_q[gnt]  <= m_rd;
                        done[gnt]  <= 1'b1;
                        m_valid    <= 1'b0;
                        cool       <= 1'b0;
                        state      <= COOL;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        done[gnt] <= 1'b1;
                        m_valid   <= 1'b0;
                        cool      <= 1'b0;
                        state     <= COOL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COOL: begin
                    if (cool) state <= IDLE;
                    cool <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
